pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Multi-cycle instruction sequencer for the core: owns the PC and steps each instruction through FETCH/EXEC/MEM.
//  Resolves branches from decoder outputs (JType, UncondJmp, jump condition) and datapath flags.
//  Issues a one-cycle commit strobe that the datapath ANDs with the decoder's RegWrite/WrMem.
//  Sits between the control decoder, instruction ROM, data memory and flag register.
// PARAMETERS
//  PC_W        10   PC / jump-target width; PC wraps modulo 2**PC_W
//  START_PC    0    PC loaded on reset and on every accepted start
//  MEM_TIMEOUT 15   max MEM-state cycles without mem_ready before error abort (>=1)
// PORTS
//  clk          in   1     clock, all state on rising edge
//  rst_n        in   1     asynchronous, active-low reset
//  start        in   1     run request; accepted only in IDLE or DONE
//  done         out  1     program finished (halt or error); held until next start
//  err          out  1     MEM timeout abort; valid while done=1
//  pc           out  PC_W  current instruction address to instruction ROM
//  fetch_en     out  1     instruction-register load strobe (FETCH state)
//  jtype        in   1     decoder: jump instruction
//  uncond_jmp   in   1     decoder: unconditional jump
//  jcond        in   2     jump condition: 0=EQ(Z) 1=NE(!Z) 2=LT(N) 3=GE(!N)
//  halt         in   1     decoder: halt instruction
//  rd_mem       in   1     decoder: load
//  wr_mem       in   1     decoder: store
//  flag_z       in   1     registered zero flag from last cmp
//  flag_n       in   1     registered negative flag from last cmp
//  jmp_target   in   PC_W  absolute jump target
//  mem_req      out  1     data memory request (MEM state)
//  mem_ready    in   1     data memory completion
//  commit       out  1     instruction retires this cycle; gates RegWrite/WrMem
//  retired_cnt  out  16    retired-instruction count (see CONFIGURATION)
//  cycle_cnt    out  16    busy-cycle count (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state=IDLE, pc=START_PC, done=0, err=0, fetch_en=0, mem_req=0, commit=0, counters=0, timeout=0.
//  States: IDLE, FETCH, EXEC, MEM, DONE (Moore outputs; commit is Mealy in MEM).
//  IDLE:  start=1 -> FETCH, pc<=START_PC.
//  FETCH: fetch_en=1 for exactly one cycle -> EXEC. Decoder inputs are valid from the EXEC cycle.
//  EXEC:  halt=1 -> DONE, done<=1, err<=0, no commit; halt has priority over everything.
//         else rd_mem|wr_mem -> MEM, timeout<=0.
//         else commit=1, update pc, -> FETCH.
//  MEM:   mem_req=1 for every cycle in state; mem_ready=1 -> commit=1, update pc, -> FETCH.
//         mem_ready in the first MEM cycle is accepted (one-cycle memory).
//         timeout increments each non-ready cycle; reaching MEM_TIMEOUT -> DONE, done<=1, err<=1, no commit.
//  DONE:  done held; start=1 -> FETCH, pc<=START_PC, done<=0, err<=0.
//  Latency: non-memory instruction = 2 cycles; memory instruction = 2 + k cycles (k = MEM cycles incl. ready cycle).
//  PC update at commit: taken = jtype & (uncond_jmp | cond(jcond,flag_z,flag_n)).
//         pc <= taken ? jmp_target : pc+1 (mod 2**PC_W; max value wraps to 0). Jump-to-self is legal.
//  jtype=0: uncond_jmp/jcond ignored. jtype with rd_mem/wr_mem: memory path first, branch resolved at commit.
//  start outside IDLE/DONE: ignored. rst_n low in any state: immediate async return to reset values.
//  Exactly one commit per retired instruction; never commit in FETCH, IDLE or DONE.
// CONFIGURATION
//  PC_SEQ_PERF_CNT_EN defined:
//    retired_cnt increments on commit; cycle_cnt increments every cycle in FETCH/EXEC/MEM.
//    Both saturate at 16'hFFFF, clear on reset and on accepted start, hold in IDLE/DONE.
//  Macro undefined: retired_cnt and cycle_cnt tied to 0; no counter flops.
// STRUCTURE
//  Package seq_pkg: state_t enum; jcond encodings JC_EQ/JC_NE/JC_LT/JC_GE; PERF_W=16.
//  Sub-module branch_resolve (combinational): jtype, uncond_jmp, jcond, flag_z, flag_n -> taken.
//  Top holds FSM, pc register, timeout counter, optional perf counters.
// TESTING
//  1. Reset then start pulse, non-jump ALU stream of 3 instrs -> pc 0,1,2,3; commit every 2nd cycle; fetch_en 1-cycle pulses.
//  2. EXEC with jtype=1, jcond=EQ, flag_z=1, jmp_target=0x3A0 -> pc=0x3A0 after commit.
//     Repeat with flag_z=0 -> pc=pc+1.
//  3. Load with mem_ready after 3 cycles -> mem_req high 3 cycles, single commit on ready cycle.
//     Load with ready on first MEM cycle -> 3-cycle instruction.
//  4. mem_ready never arrives, MEM_TIMEOUT=15 -> after 15 MEM cycles done=1, err=1, no commit.
//     Next start -> err=0, pc=START_PC.
//  5. pc=0x3FF non-jump commit -> pc=0x000. halt with jtype=1 -> DONE, no commit, pc unchanged.
//  6. rst_n low mid-MEM -> all outputs reset asynchronously.
//     With PC_SEQ_PERF_CNT_EN, 4 retired instrs -> retired_cnt=4; undefined -> counters 0.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// Shared types for the PC sequencer: FSM state encoding, jump-condition codes and counter width.
package seq_pkg;
  localparam int PERF_W = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_MEM,
    S_DONE
  } state_t;

  localparam logic [1:0] JC_EQ = 2'd0;
  localparam logic [1:0] JC_NE = 2'd1;
  localparam logic [1:0] JC_LT = 2'd2;
  localparam logic [1:0] JC_GE = 2'd3;
endpackage

// File: rtl/pc_sequencer_if.sv
// Sequencer bundle: run control, ROM address, decoder and flag inputs, data-memory handshake, counters.
interface pc_sequencer_if #(parameter int PC_W = 10);
  import seq_pkg::*;

  logic              start;
  logic              done;
  logic              err;
  logic [PC_W-1:0]   pc;
  logic              fetch_en;
  logic              jtype;
  logic              uncond_jmp;
  logic [1:0]        jcond;
  logic              halt;
  logic              rd_mem;
  logic              wr_mem;
  logic              flag_z;
  logic              flag_n;
  logic [PC_W-1:0]   jmp_target;
  logic              mem_req;
  logic              mem_ready;
  logic              commit;
  logic [PERF_W-1:0] retired_cnt;
  logic [PERF_W-1:0] cycle_cnt;

  modport master (
    input  start, jtype, uncond_jmp, jcond, halt, rd_mem, wr_mem,
           flag_z, flag_n, jmp_target, mem_ready,
    output done, err, pc, fetch_en, mem_req, commit, retired_cnt, cycle_cnt
  );

  modport slave (
    output start, jtype, uncond_jmp, jcond, halt, rd_mem, wr_mem,
           flag_z, flag_n, jmp_target, mem_ready,
    input  done, err, pc, fetch_en, mem_req, commit, retired_cnt, cycle_cnt
  );
endinterface

// File: rtl/pc_sequencer_branch_resolve.sv
// Combinational branch decision from decoder jump fields and the registered compare flags.
module branch_resolve
  import seq_pkg::*;
(
  input  logic       i_jtype,
  input  logic       i_uncond_jmp,
  input  logic [1:0] i_jcond,
  input  logic       i_flag_z,
  input  logic       i_flag_n,
  output logic       o_taken
);
  logic w_cond;

  always_comb begin
    w_cond = 1'b0;
    case (i_jcond)
      JC_EQ: w_cond = i_flag_z;
      JC_NE: w_cond = !i_flag_z;
      JC_LT: w_cond = i_flag_n;
      JC_GE: w_cond = !i_flag_n;
    endcase
  end

  assign o_taken = i_jtype & (i_uncond_jmp | w_cond);
endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle FETCH/EXEC/MEM sequencer owning the PC; 2 cycles per instruction plus MEM wait cycles.
// Optional retired/busy-cycle counters are built only when PC_SEQ_PERF_CNT_EN is defined.
module pc_sequencer
  import seq_pkg::*;
#(
  parameter int              PC_W        = 10,
  parameter logic [PC_W-1:0] START_PC    = '0,
  parameter int              MEM_TIMEOUT = 15
) (
  input  logic           clk,
  input  logic           rst_n,
  pc_sequencer_if.master bus
);
  localparam int              TO_W   = $clog2(MEM_TIMEOUT + 1);
  localparam logic [PC_W-1:0] PC_ONE = 1;
  localparam logic [TO_W-1:0] TO_ONE = 1;
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(MEM_TIMEOUT - 1);

  state_t          r_state;
  logic [PC_W-1:0] r_pc;
  logic [TO_W-1:0] r_timeout;
  logic            r_done;
  logic            r_err;

  logic            w_taken;
  logic            w_is_mem;
  logic            w_commit;
  logic            w_start_ok;
  logic [PC_W-1:0] w_next_pc;

  branch_resolve u_branch_resolve (
    .i_jtype      (bus.jtype),
    .i_uncond_jmp (bus.uncond_jmp),
    .i_jcond      (bus.jcond),
    .i_flag_z     (bus.flag_z),
    .i_flag_n     (bus.flag_n),
    .o_taken      (w_taken)
  );

  assign w_is_mem   = bus.rd_mem | bus.wr_mem;
  // Retirement is decided in the same cycle the instruction completes, so commit is not registered.
  assign w_commit   = ((r_state == S_EXEC) && !bus.halt && !w_is_mem) ||
                      ((r_state == S_MEM) && bus.mem_ready);
  assign w_start_ok = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_next_pc  = w_taken ? bus.jmp_target : r_pc + PC_ONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_pc      <= START_PC;
      r_timeout <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.start) begin
          r_state <= S_FETCH;
          r_pc    <= START_PC;
        end
        S_FETCH: r_state <= S_EXEC;
        S_EXEC: begin
          if (bus.halt) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_err   <= 1'b0;
          end else if (w_is_mem) begin
            r_state   <= S_MEM;
            r_timeout <= '0;
          end else begin
            r_state <= S_FETCH;
            r_pc    <= w_next_pc;
          end
        end
        S_MEM: begin
          if (bus.mem_ready) begin
            r_state <= S_FETCH;
            r_pc    <= w_next_pc;
          end else if (r_timeout == TO_MAX) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_err   <= 1'b1;
          end else begin
            r_timeout <= r_timeout + TO_ONE;
          end
        end
        S_DONE: if (bus.start) begin
          r_state <= S_FETCH;
          r_pc    <= START_PC;
          r_done  <= 1'b0;
          r_err   <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.pc       = r_pc;
  assign bus.done     = r_done;
  assign bus.err      = r_err;
  assign bus.fetch_en = (r_state == S_FETCH);
  assign bus.mem_req  = (r_state == S_MEM);
  assign bus.commit   = w_commit;

`ifdef PC_SEQ_PERF_CNT_EN
  localparam logic [PERF_W-1:0] PERF_ONE = 1;

  logic [PERF_W-1:0] r_retired_cnt;
  logic [PERF_W-1:0] r_cycle_cnt;
  logic              w_busy;

  assign w_busy = (r_state == S_FETCH) || (r_state == S_EXEC) || (r_state == S_MEM);

  // Both counters saturate rather than wrap so a long run never reads as a short one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retired_cnt <= '0;
      r_cycle_cnt   <= '0;
    end else if (w_start_ok) begin
      r_retired_cnt <= '0;
      r_cycle_cnt   <= '0;
    end else begin
      if (w_commit && (r_retired_cnt != '1)) r_retired_cnt <= r_retired_cnt + PERF_ONE;
      if (w_busy && (r_cycle_cnt != '1))     r_cycle_cnt   <= r_cycle_cnt + PERF_ONE;
    end
  end

  assign bus.retired_cnt = r_retired_cnt;
  assign bus.cycle_cnt   = r_cycle_cnt;
`else
  logic w_unused_start_ok;
  assign w_unused_start_ok = w_start_ok;
  assign bus.retired_cnt   = '0;
  assign bus.cycle_cnt     = '0;
`endif
endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: driver predicts fetch/commit/done events, monitor pops and compares.
module tb_pc_sequencer;
  localparam int PC_W   = 10;
  localparam int MEM_TO = 15;

  typedef struct {int pc; int lat; int memc; int ret; int cyc; bit err;} exp_t;
  typedef struct {bit h; bit mem; bit jt; bit uj; bit [1:0] jc; bit z; bit n; int tgt; int k;} instr_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  int   fetch_q[$];
  exp_t commit_q[$];
  exp_t done_q[$];
  int   m_pc, m_ret, m_cyc;
  bit   m_done;

  pc_sequencer_if #(.PC_W(PC_W)) bus ();

  pc_sequencer #(.PC_W(PC_W), .START_PC(10'd0), .MEM_TIMEOUT(MEM_TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic bad(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: unexpected DUT event (t=%0t)", nm, $time);
  endtask

  function automatic logic [31:0] perf(input int v);
`ifdef PC_SEQ_PERF_CNT_EN
    return v;
`else
    return 0;
`endif
  endfunction

  function automatic instr_t mk(bit h, bit mem, bit jt, bit uj, bit [1:0] jc, bit z, bit n, int tgt, int k);
    instr_t r;
    r = '{h, mem, jt, uj, jc, z, n, tgt, k};
    return r;
  endfunction

  task automatic check_reset(input string tag);
    check({tag, "_pc"},       bus.pc, 0);
    check({tag, "_done"},     bus.done, 0);
    check({tag, "_err"},      bus.err, 0);
    check({tag, "_fetch_en"}, bus.fetch_en, 0);
    check({tag, "_mem_req"},  bus.mem_req, 0);
    check({tag, "_commit"},   bus.commit, 0);
    check({tag, "_retired"},  bus.retired_cnt, 0);
    check({tag, "_cycles"},   bus.cycle_cnt, 0);
  endtask

  task automatic do_start();
    m_pc = 0; m_ret = 0; m_cyc = 0; m_done = 0;
    fetch_q.push_back(0);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_fetch();
    int n = 0;
    while (!bus.fetch_en && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.fetch_en) bad("wait_fetch_timeout");
  endtask

  // Reference: one instruction's observable events from the architectural rules.
  task automatic run_instr(input instr_t in);
    int sel;
    bit cond, taken;
    wait_fetch();
    sel            = $urandom_range(0, 2);
    bus.halt       = in.h;
    bus.rd_mem     = in.mem && (sel != 1);
    bus.wr_mem     = in.mem && (sel != 0);
    bus.jtype      = in.jt;
    bus.uncond_jmp = in.uj;
    bus.jcond      = in.jc;
    bus.flag_z     = in.z;
    bus.flag_n     = in.n;
    bus.jmp_target = in.tgt[PC_W-1:0];
    bus.mem_ready  = 1'b0;
    bus.start      = ($urandom % 8) == 0;
    case (in.jc)
      2'd0:    cond = in.z;
      2'd1:    cond = !in.z;
      2'd2:    cond = in.n;
      default: cond = !in.n;
    endcase
    taken = in.jt && (in.uj || cond);
    if (in.h) begin
      done_q.push_back('{m_pc, 2, 0, m_ret, m_cyc + 2, 1'b0});
      m_cyc += 2;
      m_done = 1;
    end else if (in.mem && in.k == 0) begin
      done_q.push_back('{m_pc, 2 + MEM_TO, MEM_TO, m_ret, m_cyc + 2 + MEM_TO, 1'b1});
      m_cyc += 2 + MEM_TO;
      m_done = 1;
    end else begin
      commit_q.push_back('{m_pc, in.mem ? 1 + in.k : 1, in.mem ? in.k : 0, m_ret, 0, 1'b0});
      m_ret++;
      m_cyc += in.mem ? 2 + in.k : 2;
      m_pc = taken ? in.tgt : (m_pc + 1) % (1 << PC_W);
      fetch_q.push_back(m_pc);
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
    if (in.h || !in.mem) begin
      @(posedge clk); #1;
    end else if (in.k == 0) begin
      repeat (MEM_TO + 1) @(posedge clk);
      #1;
    end else begin
      @(posedge clk); #1;
      for (int i = 1; i <= in.k; i++) begin
        bus.mem_ready = (i == in.k);
        @(posedge clk); #1;
      end
      bus.mem_ready = 1'b0;
    end
  endtask

  initial begin : monitor
    int   sf, memc, p;
    bit   pf, pd;
    exp_t e;
    sf = 0; memc = 0; pf = 0; pd = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sf = 0; memc = 0; pf = 0; pd = 0;
      end else begin
        sf++;
        if (bus.mem_req) memc++;
        if (bus.fetch_en) begin
          check("fetch_single_pulse", pf, 0);
          if (fetch_q.size() == 0) bad("fetch_unexpected");
          else begin
            p = fetch_q.pop_front();
            check("fetch_pc", bus.pc, p);
          end
          sf = 0; memc = 0;
        end
        pf = bus.fetch_en;
        if (bus.commit) begin
          if (commit_q.size() == 0) bad("commit_unexpected");
          else begin
            e = commit_q.pop_front();
            check("commit_pc", bus.pc, e.pc);
            check("commit_latency", sf, e.lat);
            check("commit_mem_cycles", memc, e.memc);
            check("commit_retired_cnt", bus.retired_cnt, perf(e.ret));
          end
        end
        if (bus.done && !pd) begin
          if (done_q.size() == 0) bad("done_unexpected");
          else begin
            e = done_q.pop_front();
            check("done_err", bus.err, e.err);
            check("done_pc", bus.pc, e.pc);
            check("done_latency", sf, e.lat);
            check("done_mem_cycles", memc, e.memc);
            check("done_retired_cnt", bus.retired_cnt, perf(e.ret));
            check("done_cycle_cnt", bus.cycle_cnt, perf(e.cyc));
          end
        end
        pd = bus.done;
      end
    end
  end

  initial begin : watchdog
    #400000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : driver
    bus.start = 0; bus.jtype = 0; bus.uncond_jmp = 0; bus.jcond = 0; bus.halt = 0;
    bus.rd_mem = 0; bus.wr_mem = 0; bus.flag_z = 0; bus.flag_n = 0;
    bus.jmp_target = '0; bus.mem_ready = 0;
    m_pc = 0; m_ret = 0; m_cyc = 0; m_done = 0;
    repeat (2) @(posedge clk);
    #1;
    check_reset("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_reset("idle");

    do_start();
    repeat (3) run_instr(mk(0, 0, 0, 0, 2'd0, 0, 0, 0, 1));
    run_instr(mk(0, 0, 1, 0, 2'd0, 1, 0, 'h3A0, 1));
    run_instr(mk(0, 0, 1, 0, 2'd0, 0, 0, 'h3A0, 1));
    run_instr(mk(0, 1, 0, 0, 2'd0, 0, 0, 0, 3));
    run_instr(mk(0, 1, 0, 0, 2'd0, 0, 0, 0, 1));
    run_instr(mk(0, 0, 1, 1, 2'd2, 0, 0, 'h3FF, 1));
    run_instr(mk(0, 0, 0, 0, 2'd0, 0, 0, 0, 1));
    run_instr(mk(1, 0, 1, 1, 2'd0, 0, 0, 'h155, 1));

    do_start();
    run_instr(mk(0, 1, 0, 0, 2'd0, 0, 0, 0, 0));
    repeat (3) @(posedge clk);
    #1;
    check("timeout_done_held", bus.done, 1);
    do_start();
    check("restart_err", bus.err, 0);
    check("restart_done", bus.done, 0);
    check("restart_pc", bus.pc, 0);

    for (int i = 0; i < 300; i++) begin
      instr_t in;
      if (m_done) begin
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
        do_start();
      end
      in = mk(($urandom % 20) == 0, ($urandom % 4) == 0, ($urandom % 3) == 0, 1'($urandom % 2),
              2'($urandom % 4), 1'($urandom % 2), 1'($urandom % 2), int'($urandom % 1024),
              (($urandom % 30) == 0) ? 0 : int'($urandom_range(1, 4)));
      run_instr(in);
    end
    if (!m_done) run_instr(mk(1, 0, 0, 0, 2'd0, 0, 0, 0, 1));

    do_start();
    wait_fetch();
    bus.halt = 0; bus.rd_mem = 1; bus.wr_mem = 0; bus.mem_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    check("pre_reset_mem_req", bus.mem_req, 1);
    rst_n = 1'b0;
    #1;
    check_reset("async_reset");
    @(posedge clk); #2;
    rst_n = 1'b1;
    bus.rd_mem = 0;
    @(posedge clk); #1;

    do_start();
    repeat (4) run_instr(mk(0, 0, 0, 0, 2'd0, 0, 0, 0, 1));
    run_instr(mk(1, 0, 0, 0, 2'd0, 0, 0, 0, 1));

    repeat (5) @(posedge clk);
    #1;
    check("fetch_q_drained", fetch_q.size(), 0);
    check("commit_q_drained", commit_q.size(), 0);
    check("done_q_drained", done_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
